// File: rtl/edge_cnt_pkg.sv
// Shared codes for the edge event counter.
// Edge-select encodings used by edge_event_counter.
package edge_cnt_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser, edge detector and post-reset arming
// for one asynchronous input.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o,
    output logic armed_o
);

    localparam int ARM_LAST = SYNC_STAGES + 1;
    localparam int AW = $clog2(ARM_LAST + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [AW-1:0]          arm_cnt_q;
    logic                   armed_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= s;
            if (!armed_q) begin
                if (arm_cnt_q == AW'(ARM_LAST)) begin
                    armed_q <= 1'b1;
                end else begin
                    arm_cnt_q <= arm_cnt_q + AW'(1);
                end
            end
        end
    end

    // Edges are masked until the chain and prev flop hold real samples.
    assign rise_o  = armed_q & s & ~prev_q;
    assign fall_o  = armed_q & ~s & prev_q;
    assign armed_o = armed_q;

endmodule

// File: rtl/edge_event_counter.sv
// Counts qualified edges of an asynchronous input with
// up/down, wrap/saturate, load, compare and boundary flags.
module edge_event_counter
    import edge_cnt_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_sig,
    input  logic [1:0]       edge_sel,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             ovf,
    output logic             udf,
    output logic             armed
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic             rise;
    logic             fall;
    logic             qual;
    logic             ev;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (in_sig),
        .rise_o (rise),
        .fall_o (fall),
        .armed_o(armed)
    );

    always_comb begin
        qual = 1'b0;
        unique case (edge_sel_e'(edge_sel))
            EDGE_NONE: qual = 1'b0;
            EDGE_RISE: qual = rise;
            EDGE_FALL: qual = fall;
            EDGE_BOTH: qual = rise | fall;
            default:   qual = 1'b0;
        endcase
    end

    assign ev = en & qual;

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (ev && dir) begin
            if (count_q == MAX) begin
                count_d = SATURATE ? MAX : '0;
                ovf_d   = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (ev) begin
            if (count_q == '0) begin
                count_d = SATURATE ? '0 : MAX;
                udf_d   = 1'b1;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;
    assign match = (count_q == cmp_val);

endmodule

// File: tb/tb_edge_event_counter.sv
// Directed bench: a wrapping and a saturating counter
// driven in parallel from the same stimulus.
module tb_edge_event_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_sig;
    logic [1:0] edge_sel;
    logic       en, dir, clr, load;
    logic [3:0] load_val, cmp_val;

    logic [3:0] w_count, s_count;
    logic       w_match, w_ovf, w_udf, w_armed;
    logic       s_match, s_ovf, s_udf, s_armed;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    edge_event_counter #(.WIDTH(4), .SYNC_STAGES(2), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_sig(in_sig), .edge_sel(edge_sel),
        .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .cmp_val(cmp_val),
        .count(w_count), .match(w_match), .ovf(w_ovf), .udf(w_udf),
        .armed(w_armed)
    );

    edge_event_counter #(.WIDTH(4), .SYNC_STAGES(2), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_sig(in_sig), .edge_sel(edge_sel),
        .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .cmp_val(cmp_val),
        .count(s_count), .match(s_match), .ovf(s_ovf), .udf(s_udf),
        .armed(s_armed)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // New in_sig level reaches count on the third clock edge.
    task automatic drive(input logic v);
        in_sig = v;
        step(3);
    endtask

    task automatic test_reset;
        rst = 1'b0; in_sig = 1'b1; edge_sel = 2'b11;
        en = 1'b1; dir = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = 4'd0; cmp_val = 4'd0;
        step(2);
        n_cmp++;
        if (w_count !== 4'd0 || w_ovf !== 1'b0 || w_udf !== 1'b0 || w_armed !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vals: cnt=%0d ovf=%b udf=%b armed=%b need 0/0/0/0",
                     w_count, w_ovf, w_udf, w_armed);
        end
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            n_cmp++;
            if (w_armed !== 1'b0 || w_count !== 4'd0) begin
                n_bad++;
                $display("FAIL arm_wait%0d: armed=%b cnt=%0d need 0/0", k, w_armed, w_count);
            end
        end
        step(1);
        n_cmp++;
        if (w_armed !== 1'b1 || s_armed !== 1'b1) begin
            n_bad++;
            $display("FAIL armed_set: w=%b s=%b need 1", w_armed, s_armed);
        end
        step(4);
        n_cmp++;
        if (w_count !== 4'd0 || s_count !== 4'd0) begin
            n_bad++;
            $display("FAIL no_spurious: w=%0d s=%0d need 0", w_count, s_count);
        end
    endtask

    task automatic test_wrap_up;
        logic [3:0] exp;
        edge_sel = 2'b01; dir = 1'b1;
        drive(1'b0);
        for (int i = 1; i <= 17; i++) begin
            exp = 4'(i % 16);
            drive(1'b1);
            n_cmp++;
            if (w_count !== exp || w_ovf !== (i == 16)) begin
                n_bad++;
                $display("FAIL wrap_up%0d: cnt=%0d ovf=%b need %0d/%b",
                         i, w_count, w_ovf, exp, (i == 16));
            end
            drive(1'b0);
            n_cmp++;
            if (w_count !== exp || w_ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL wrap_hold%0d: cnt=%0d ovf=%b need %0d/0",
                         i, w_count, w_ovf, exp);
            end
        end
    endtask

    task automatic test_sat_down;
        logic [3:0] exp_s [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        logic       exp_su[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_w [4] = '{4'd1, 4'd0, 4'd15, 4'd14};
        logic       exp_wu[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        dir = 1'b0; load_val = 4'd2; load = 1'b1;
        step(1);
        load = 1'b0;
        n_cmp++;
        if (s_count !== 4'd2 || w_count !== 4'd2) begin
            n_bad++;
            $display("FAIL load2: s=%0d w=%0d need 2", s_count, w_count);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1);
            n_cmp++;
            if (s_count !== exp_s[i] || s_udf !== exp_su[i]) begin
                n_bad++;
                $display("FAIL sat_down%0d: cnt=%0d udf=%b need %0d/%b",
                         i + 1, s_count, s_udf, exp_s[i], exp_su[i]);
            end
            n_cmp++;
            if (w_count !== exp_w[i] || w_udf !== exp_wu[i]) begin
                n_bad++;
                $display("FAIL wrap_down%0d: cnt=%0d udf=%b need %0d/%b",
                         i + 1, w_count, w_udf, exp_w[i], exp_wu[i]);
            end
            drive(1'b0);
            n_cmp++;
            if (s_udf !== 1'b0 || w_udf !== 1'b0) begin
                n_bad++;
                $display("FAIL udf_clear%0d: s=%b w=%b need 0", i + 1, s_udf, w_udf);
            end
        end
    endtask

    task automatic test_edge_modes;
        dir = 1'b1; edge_sel = 2'b11; clr = 1'b1;
        step(1);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1);
            drive(1'b0);
        end
        n_cmp++;
        if (w_count !== 4'd10 || s_count !== 4'd10) begin
            n_bad++;
            $display("FAIL both_edges: w=%0d s=%0d need 10", w_count, s_count);
        end
        edge_sel = 2'b10;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1);
            drive(1'b0);
        end
        n_cmp++;
        if (w_count !== 4'd15 || w_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL fall_edges: cnt=%0d ovf=%b need 15/0", w_count, w_ovf);
        end
        edge_sel = 2'b00;
        drive(1'b1);
        drive(1'b0);
        n_cmp++;
        if (w_count !== 4'd15) begin
            n_bad++;
            $display("FAIL no_edges: cnt=%0d need 15", w_count);
        end
    endtask

    task automatic test_priority;
        edge_sel = 2'b01; dir = 1'b1; cmp_val = 4'd9;
        in_sig = 1'b1;
        step(2);
        clr = 1'b1; load = 1'b1; load_val = 4'd9;
        step(1);
        clr = 1'b0; load = 1'b0;
        n_cmp++;
        if (w_count !== 4'd0 || w_match !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_wins: cnt=%0d match=%b need 0/0", w_count, w_match);
        end
        drive(1'b0);
        load_val = 4'd15; load = 1'b1;
        step(1);
        load = 1'b0;
        load_val = 4'd9;
        in_sig = 1'b1;
        step(2);
        load = 1'b1;
        step(1);
        load = 1'b0;
        n_cmp++;
        if (w_count !== 4'd9 || w_ovf !== 1'b0 || w_match !== 1'b1) begin
            n_bad++;
            $display("FAIL load_wins: cnt=%0d ovf=%b match=%b need 9/0/1",
                     w_count, w_ovf, w_match);
        end
        step(1);
        n_cmp++;
        if (w_count !== 4'd9 || w_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ev_dropped: cnt=%0d ovf=%b need 9/0", w_count, w_ovf);
        end
        drive(1'b0);
    endtask

    task automatic test_mid_reset;
        load_val = 4'd6; load = 1'b1;
        step(1);
        load = 1'b0;
        drive(1'b1);
        n_cmp++;
        if (w_count !== 4'd7) begin
            n_bad++;
            $display("FAIL pre_rst: cnt=%0d need 7", w_count);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (w_count !== 4'd0 || w_ovf !== 1'b0 || w_udf !== 1'b0 || w_armed !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst: cnt=%0d ovf=%b udf=%b armed=%b need 0/0/0/0",
                     w_count, w_ovf, w_udf, w_armed);
        end
        step(1);
        rst = 1'b1;
        step(3);
        n_cmp++;
        if (w_armed !== 1'b0) begin
            n_bad++;
            $display("FAIL rearm_wait: armed=%b need 0", w_armed);
        end
        step(1);
        n_cmp++;
        if (w_armed !== 1'b1 || w_count !== 4'd0) begin
            n_bad++;
            $display("FAIL rearm_done: armed=%b cnt=%0d need 1/0", w_armed, w_count);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_edge_modes();
        test_priority();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
